// File: rtl/controls_uart_in_pkg.sv
// Shared constants for the controls input port: register map, edge encodings, debounce width.
// Latency: n/a (package only).
// Backpressure: n/a. Optional feature macro: CONTROLS_UART_IN_DEBOUNCE_EN.
package controls_uart_pkg;

   // Word addresses on the Avalon-MM slave, matching the controls output port map
   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   // Per-bit edge sensitivity selected by the EDGE_TYPE parameter
   localparam int EDGE_RISING  = 0;
   localparam int EDGE_FALLING = 1;
   localparam int EDGE_ANY     = 2;

   // Stability counter width for the optional debounce stage (16 stable cycles)
   localparam int DEBOUNCE_CNT_W = 4;

endpackage

// File: rtl/controls_uart_in_if.sv
// Avalon-MM slave bus plus level interrupt for the controls input port.
// Latency: n/a (signal bundle only).
// Backpressure: none; the slave never inserts wait states.
interface controls_uart_in_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        read_n;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, read_n, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, read_n, write_n, writedata,
      output readdata, irq
   );

endinterface

// File: rtl/controls_uart_in_sync.sv
// Brings the asynchronous status bus into clk through a flop chain, optionally debounced.
// Latency: SYNC_STAGES cycles (plus 16 when CONTROLS_UART_IN_DEBOUNCE_EN is defined).
// Backpressure: none; samples every cycle.
module controls_uart_in_sync
   import controls_uart_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_async,
   output logic [WIDTH-1:0] o_data_in
);

   logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
   logic [WIDTH-1:0]                  w_synced;

   // Shift the raw bus through the synchronizer chain; stage 0 is the metastable one
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      end
   end

   assign w_synced = r_sync[SYNC_STAGES-1];

`ifdef CONTROLS_UART_IN_DEBOUNCE_EN
   logic [WIDTH-1:0][DEBOUNCE_CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0]                     r_data_in;

   // Per bit: count consecutive cycles the synced value differs from the accepted one;
   // accept it on the 16th such cycle, restart the count whenever it agrees again
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt     <= '0;
         r_data_in <= '0;
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (w_synced[i] != r_data_in[i]) begin
               if (r_cnt[i] == {DEBOUNCE_CNT_W{1'b1}}) begin
                  r_data_in[i] <= w_synced[i];
                  r_cnt[i]     <= '0;
               end else begin
                  r_cnt[i] <= r_cnt[i] + DEBOUNCE_CNT_W'(1);
               end
            end else begin
               r_cnt[i] <= '0;
            end
         end
      end
   end

   assign o_data_in = r_data_in;
`else
   assign o_data_in = w_synced;
`endif

endmodule

// File: rtl/controls_uart_in.sv
// Avalon-MM input port: synced status bus, sticky edge capture, maskable level IRQ.
// Latency: data_in after SYNC_STAGES cycles, edgecapture +1, irq +1; readdata 1 cycle after a read.
// Backpressure: none, no wait states. Debounce option macro: CONTROLS_UART_IN_DEBOUNCE_EN.
module controls_uart_in
   import controls_uart_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int EDGE_TYPE   = EDGE_RISING,
   parameter int SYNC_STAGES = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [WIDTH-1:0]   in_port,
   controls_uart_in_if.slave  bus
);

   logic [WIDTH-1:0] w_data_in;
   logic [WIDTH-1:0] r_prev;
   logic [WIDTH-1:0] r_irqmask;
   logic [WIDTH-1:0] r_edgecap;
   logic [WIDTH-1:0] w_edge;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_wdata;
   logic [31:0]      w_wdata_unused;
   logic [31:0]      w_rd_mux;
   logic [31:0]      r_readdata;
   logic             r_irq;
   logic             w_rd;
   logic             w_wr;

   controls_uart_in_sync #(
      .WIDTH       (WIDTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk       (clk),
      .reset     (reset),
      .i_async   (in_port),
      .o_data_in (w_data_in)
   );

   assign w_rd           = bus.chipselect & ~bus.read_n;
   assign w_wr           = bus.chipselect & ~bus.write_n;
   // Only the low WIDTH bits of writedata carry register content
   assign w_wdata_unused = bus.writedata;
   assign w_wdata        = w_wdata_unused[WIDTH-1:0];

   // Edge detect between the current synced value and its one-cycle-old copy
   always_comb begin
      w_edge = '0;
      case (EDGE_TYPE)
         EDGE_FALLING: w_edge = ~w_data_in & r_prev;
         EDGE_ANY:     w_edge = w_data_in ^ r_prev;
         default:      w_edge = w_data_in & ~r_prev;
      endcase
   end

   assign w_clr = (w_wr && bus.address == ADDR_EDGECAP) ? w_wdata : '0;

   // Delay data_in by one cycle for the edge comparison
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_prev <= '0;
      else       r_prev <= w_data_in;
   end

   // Interrupt mask loads from the bus
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    r_irqmask <= '0;
      else if (w_wr && bus.address == ADDR_IRQMASK) r_irqmask <= w_wdata;
   end

   // Sticky capture, write-1-to-clear; a fresh edge beats a clear on the same bit
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_edgecap <= '0;
      else       r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
   end

   // Level interrupt from any unmasked captured edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_irq <= 1'b0;
      else       r_irq <= |(r_edgecap & r_irqmask);
   end

   // Read mux over current register values, zero-extended to the bus width
   always_comb begin
      w_rd_mux = '0;
      case (bus.address)
         ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_data_in;
         ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
         ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
         default:      w_rd_mux = '0;
      endcase
   end

   // Register read data on a read access, otherwise hold the last value
   always_ff @(posedge clk or posedge reset) begin
      if (reset)     r_readdata <= '0;
      else if (w_rd) r_readdata <= w_rd_mux;
   end

   assign bus.readdata = r_readdata;
   assign bus.irq      = r_irq;

endmodule
